// File: rtl/shift_ex_stage.sv
// Two-stage shift execute stage: S1 captures (forwarded) operands, S2 holds the shifted result.
// Valid/ready handshake on both sides, flush discards everything in flight.
module shift_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_use_imm,
    input  logic [4:0]      in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd,
    input  logic            fwd_en,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic [15:0]     op_count
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    logic            s1Valid_q, s1Valid_d;
    logic [1:0]      s1Op_q, s1Op_d;
    logic [4:0]      s1Amt_q, s1Amt_d;
    logic [XLEN-1:0] s1Rs1_q, s1Rs1_d;
    logic [4:0]      s1Rd_q, s1Rd_d;

    logic            s2Valid_q, s2Valid_d;
    logic [XLEN-1:0] s2Data_q, s2Data_d;
    logic [4:0]      s2Rd_q, s2Rd_d;

    logic [15:0]     opCount_q, opCount_d;

    logic            s1Adv;
    logic            accept;
    logic [XLEN-1:0] rs1Sel;
    logic [XLEN-1:0] rs2Sel;
    logic [XLEN-1:0] shiftResult;

    // Register index 0 is hard-wired zero in the register file, so it never takes the bypass.
    always_comb begin
        rs1Sel = (fwd_en && (fwd_rd != 5'd0) && (fwd_rd == in_rs1_addr)) ? fwd_data : in_rs1;
        rs2Sel = (fwd_en && (fwd_rd != 5'd0) && (fwd_rd == in_rs2_addr)) ? fwd_data : in_rs2;
    end

    always_comb begin
        s1Adv    = s1Valid_q && (!s2Valid_q || out_ready);
        in_ready = !rst && !flush && (!s1Valid_q || s1Adv);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Op_d    = s1Op_q;
        s1Amt_d   = s1Amt_q;
        s1Rs1_d   = s1Rs1_q;
        s1Rd_d    = s1Rd_q;
        if (flush) begin
            s1Valid_d = 1'b0;
        end else if (accept) begin
            s1Valid_d = 1'b1;
            s1Op_d    = in_op;
            s1Amt_d   = in_use_imm ? in_imm : 5'(rs2Sel);
            s1Rs1_d   = rs1Sel;
            s1Rd_d    = in_rd;
        end else if (s1Adv) begin
            s1Valid_d = 1'b0;
        end
    end

    always_comb begin
        shiftResult = s1Rs1_q;
        case (s1Op_q)
            OP_SLL:  shiftResult = s1Rs1_q << s1Amt_q;
            OP_SRL:  shiftResult = s1Rs1_q >> s1Amt_q;
            OP_SRA:  shiftResult = $signed(s1Rs1_q) >>> s1Amt_q;
            OP_PASS: shiftResult = s1Rs1_q;
            default: shiftResult = s1Rs1_q;
        endcase
    end

    // S2 holds its contents while the memory stage stalls; a flush wins over any advance.
    always_comb begin
        s2Valid_d = s2Valid_q;
        s2Data_d  = s2Data_q;
        s2Rd_d    = s2Rd_q;
        if (flush) begin
            s2Valid_d = 1'b0;
        end else if (s1Adv) begin
            s2Valid_d = 1'b1;
            s2Data_d  = shiftResult;
            s2Rd_d    = s1Rd_q;
        end else if (out_ready) begin
            s2Valid_d = 1'b0;
        end
    end

    always_comb begin
        opCount_d = opCount_q;
        if (s2Valid_q && out_ready && !flush && (opCount_q != 16'hFFFF)) begin
            opCount_d = opCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Op_q    <= 2'b00;
            s1Amt_q   <= 5'd0;
            s1Rs1_q   <= '0;
            s1Rd_q    <= 5'd0;
            s2Valid_q <= 1'b0;
            s2Data_q  <= '0;
            s2Rd_q    <= 5'd0;
            opCount_q <= 16'd0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Op_q    <= s1Op_d;
            s1Amt_q   <= s1Amt_d;
            s1Rs1_q   <= s1Rs1_d;
            s1Rd_q    <= s1Rd_d;
            s2Valid_q <= s2Valid_d;
            s2Data_q  <= s2Data_d;
            s2Rd_q    <= s2Rd_d;
            opCount_q <= opCount_d;
        end
    end

    assign out_valid = s2Valid_q;
    assign out_data  = s2Data_q;
    assign out_rd    = s2Rd_q;
    assign op_count  = opCount_q;

endmodule
